dc_pred_sched: RTL and testbench
================================

// Module: dc_pred_sched
// PURPOSE
//  Sequences quantised 8x8 blocks into the DC Huffman encoder in MCU order.
//  Fixed 4:2:0-style slot order: Y_PER_MCU luma blocks, then Cb, then Cr.
//  Keeps one DC predictor per component and computes DIFF = DC - PRED.
//  Issues one encode request per block and waits for the encoder's done.
//  Handles frame start and restart-interval predictor resets.
// PARAMETERS
//  DC_W         16  DC coefficient / DIFF width, two's complement
//  Y_PER_MCU    4   luma blocks per MCU (1..4); MCU length = Y_PER_MCU+2 slots
//  RST_INTERVAL 0   MCUs between restart markers; 0 = restarts disabled
//  MCU_CNT_W    16  width of the MCU counter (must hold RST_INTERVAL)
// PORTS
//  clk_i          in   1          single clock
//  rst_i          in   1          synchronous, active-high reset
//  frame_start_i  in   1          1-cycle pulse: new picture
//  blk_valid_i    in   1          block DC available
//  blk_dc_i       in   DC_W       block DC value, signed
//  blk_ready_o    out  1          block accepted when valid & ready
//  enc_go_o       out  1          1-cycle request to DC encoder
//  enc_diff_o     out  DC_W       DIFF to encode, signed
//  enc_chroma_o   out  1          0 = luma table, 1 = chroma table
//  enc_done_i     in   1          encoder finished current DIFF
//  mcu_done_o     out  1          1-cycle pulse: last slot of MCU encoded
//  rst_marker_o   out  1          1-cycle pulse: emit RSTn before next MCU
//  rst_idx_o      out  3          n of the RSTn marker (mod 8)
//  busy_o         out  1          FSM not in IDLE
// BEHAVIOUR
//  Reset (rst_i=1 at a clk edge): FSM=IDLE, slot=0, mcu_cnt=0, rst_idx=0.
//   Y/Cb/Cr predictors are cleared to 0. All outputs are 0.
//   blk_ready_o=0 while rst_i=1.
//  FSM states IDLE -> ISSUE -> WAIT -> ADVANCE -> IDLE.
//  IDLE: blk_ready_o = ~frame_start_i. On accept, comp = slot<Y_PER_MCU ? Y :
//   (slot==Y_PER_MCU ? Cb : Cr). The block then updates:
//   - enc_diff_o <= blk_dc_i - pred[comp] (mod 2^DC_W)
//   - pred[comp] <= blk_dc_i
//   - enc_chroma_o <= (comp!=Y)
//   FSM goes to ISSUE.
//  ISSUE: enc_go_o=1 for exactly this cycle, then WAIT. enc_diff_o and
//   enc_chroma_o stay stable from ISSUE until ADVANCE completes.
//  WAIT: hold until enc_done_i=1, then ADVANCE. enc_done_i is ignored outside WAIT.
//  ADVANCE: slot++.
//   - If slot was Y_PER_MCU+1: slot=0, mcu_done_o=1, mcu_cnt++.
//   - If additionally RST_INTERVAL!=0 and new mcu_cnt==RST_INTERVAL:
//     mcu_cnt=0, all preds=0, rst_marker_o=1 with rst_idx_o=current idx,
//     then rst_idx++ (wraps 7->0). rst_idx_o holds its value between pulses.
//   FSM returns to IDLE.
//  Latency: accept at cycle t -> enc_go_o at t+1. Done seen at cycle k ->
//   ADVANCE at k+1 -> blk_ready_o=1 at k+2. At most one block in flight.
//  frame_start_i has priority in every state. It clears preds, slot, mcu_cnt
//   and rst_idx, and forces IDLE next cycle.
//   - If it arrives in ISSUE: enc_go_o is still 0 that cycle.
//   - If it arrives in WAIT: the late enc_done_i is ignored.
//   - No block is accepted in the frame_start_i cycle.
//  The first block after frame/restart gets DIFF = DC (pred = 0).
//  Mid-operation rst_i behaves identically to power-up reset. Pulse outputs
//   drop in the same cycle.
// TESTING
//  T1: frame_start; Y DCs 10,12,9,9, Cb 5, Cr -3, encoder done 3 cyc after go
//      -> diffs 10,2,-3,0,5,-3; chroma 0,0,0,0,1,1; one mcu_done_o on Cr.
//  T2: 2 MCUs, Y=100 all, Cb=-50, Cr=20 -> MCU2 diffs all 0; MCU1 Y0=100, Cb=-50, Cr=20.
//  T3: RST_INTERVAL=1, 9 MCUs -> rst_marker_o 9x, rst_idx_o 0..7,0.
//      Each MCU's first Y diff equals its raw DC.
//  T4: frame_start_i during WAIT, then enc_done_i -> done ignored, blk_ready_o=1.
//      Next Y DC 7 yields diff 7, chroma 0.
//  T5: DC=2047 then -2048 on Y (DC_W=12) -> diff wraps to 1 (mod 4096), no X/hang.
//  T6: blk_valid_i held high, done after 0 cycles -> accept every 4 cycles.
//      enc_go_o never exceeds 1 cycle; rst_i mid-WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/dc_pred_sched_if.sv
// Block/encoder handshake bundle for dc_pred_sched.
// DUT side uses slave, driver side uses master.
interface dc_pred_sched_if #(
  parameter int DC_W = 16
);
  logic            frame_start_i;
  logic            blk_valid_i;
  logic [DC_W-1:0] blk_dc_i;
  logic            blk_ready_o;
  logic            enc_go_o;
  logic [DC_W-1:0] enc_diff_o;
  logic            enc_chroma_o;
  logic            enc_done_i;
  logic            mcu_done_o;
  logic            rst_marker_o;
  logic [2:0]      rst_idx_o;
  logic            busy_o;

  modport master (
    output frame_start_i, blk_valid_i,
    output blk_dc_i, enc_done_i,
    input  blk_ready_o, enc_go_o,
    input  enc_diff_o, enc_chroma_o,
    input  mcu_done_o, rst_marker_o,
    input  rst_idx_o, busy_o
  );

  modport slave (
    input  frame_start_i, blk_valid_i,
    input  blk_dc_i, enc_done_i,
    output blk_ready_o, enc_go_o,
    output enc_diff_o, enc_chroma_o,
    output mcu_done_o, rst_marker_o,
    output rst_idx_o, busy_o
  );
endinterface

// File: rtl/dc_pred_sched.sv
// DC predictor / scheduler: feeds DC DIFFs
// to the Huffman encoder in MCU slot order.
module dc_pred_sched #(
  parameter int DC_W         = 16,
  parameter int Y_PER_MCU    = 4,
  parameter int RST_INTERVAL = 0,
  parameter int MCU_CNT_W    = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  dc_pred_sched_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ADV   = 2'd3;

  localparam logic [2:0] Y_N  = 3'(Y_PER_MCU);
  localparam logic [2:0] LAST = 3'(Y_PER_MCU + 1);
  localparam logic [MCU_CNT_W-1:0] RI =
    MCU_CNT_W'(RST_INTERVAL);

  logic [1:0]           state_q, state_d;
  logic [2:0]           slot_q, slot_d;
  logic [MCU_CNT_W-1:0] mcu_q, mcu_d;
  logic [2:0]           idx_q, idx_d;
  logic [DC_W-1:0]      pred_y_q, pred_y_d;
  logic [DC_W-1:0]      pred_cb_q, pred_cb_d;
  logic [DC_W-1:0]      pred_cr_q, pred_cr_d;
  logic [DC_W-1:0]      diff_q, diff_d;
  logic                 chroma_q, chroma_d;

  logic                 fs;
  logic                 last;
  logic                 rst_hit;
  logic [MCU_CNT_W-1:0] mcu_inc;

  // MCU wrap and restart-interval detection
  always_comb begin
    fs      = bus.frame_start_i;
    last    = (slot_q == LAST);
    mcu_inc = mcu_q + MCU_CNT_W'(1);
    rst_hit = (RST_INTERVAL != 0) && last &&
              (mcu_inc == RI);
  end

  // next-state, predictor and DIFF computation
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    mcu_d     = mcu_q;
    idx_d     = idx_q;
    pred_y_d  = pred_y_q;
    pred_cb_d = pred_cb_q;
    pred_cr_d = pred_cr_q;
    diff_d    = diff_q;
    chroma_d  = chroma_q;
    if (fs) begin
      state_d   = S_IDLE;
      slot_d    = '0;
      mcu_d     = '0;
      idx_d     = '0;
      pred_y_d  = '0;
      pred_cb_d = '0;
      pred_cr_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.blk_valid_i) begin
            state_d = S_ISSUE;
            unique case (1'b1)
              (slot_q < Y_N): begin
                diff_d   = bus.blk_dc_i - pred_y_q;
                pred_y_d = bus.blk_dc_i;
                chroma_d = 1'b0;
              end
              (slot_q == Y_N): begin
                diff_d    = bus.blk_dc_i - pred_cb_q;
                pred_cb_d = bus.blk_dc_i;
                chroma_d  = 1'b1;
              end
              default: begin
                diff_d    = bus.blk_dc_i - pred_cr_q;
                pred_cr_d = bus.blk_dc_i;
                chroma_d  = 1'b1;
              end
            endcase
          end
        end
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (bus.enc_done_i) state_d = S_ADV;
        end
        default: begin
          state_d = S_IDLE;
          if (last) begin
            slot_d = '0;
            mcu_d  = mcu_inc;
            if (rst_hit) begin
              mcu_d     = '0;
              idx_d     = idx_q + 3'd1;
              pred_y_d  = '0;
              pred_cb_d = '0;
              pred_cr_d = '0;
            end
          end else begin
            slot_d = slot_q + 3'd1;
          end
        end
      endcase
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      slot_q    <= '0;
      mcu_q     <= '0;
      idx_q     <= '0;
      pred_y_q  <= '0;
      pred_cb_q <= '0;
      pred_cr_q <= '0;
      diff_q    <= '0;
      chroma_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      mcu_q     <= mcu_d;
      idx_q     <= idx_d;
      pred_y_q  <= pred_y_d;
      pred_cb_q <= pred_cb_d;
      pred_cr_q <= pred_cr_d;
      diff_q    <= diff_d;
      chroma_q  <= chroma_d;
    end
  end

  // pulses drop immediately on reset or frame start
  always_comb begin
    bus.blk_ready_o  = ~rst_i & ~fs &
                       (state_q == S_IDLE);
    bus.enc_go_o     = ~rst_i & ~fs &
                       (state_q == S_ISSUE);
    bus.mcu_done_o   = ~rst_i & ~fs &
                       (state_q == S_ADV) & last;
    bus.rst_marker_o = ~rst_i & ~fs &
                       (state_q == S_ADV) & rst_hit;
    bus.rst_idx_o    = idx_q;
    bus.busy_o       = (state_q != S_IDLE);
    bus.enc_diff_o   = diff_q;
    bus.enc_chroma_o = chroma_q;
  end

endmodule

// File: tb/tb_dc_pred_sched.sv
// Directed bench for dc_pred_sched: instance A
// (16-bit, no restarts), instance B (12-bit, RI=1).
module tb_dc_pred_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, sel;
  logic fs, v, done;
  logic [15:0] dc;

  logic o_ready, o_go, o_chroma, o_mcu;
  logic o_mk, o_busy;
  logic [2:0] o_idx;
  logic [15:0] o_diff;

  int total = 0;
  int bad = 0;

  dc_pred_sched_if #(.DC_W(16)) ia ();
  dc_pred_sched_if #(.DC_W(12)) ib ();

  dc_pred_sched #(
    .DC_W(16), .Y_PER_MCU(4),
    .RST_INTERVAL(0), .MCU_CNT_W(16)
  ) ua (
    .clk_i(clk), .rst_i(rst_a), .bus(ia.slave)
  );

  dc_pred_sched #(
    .DC_W(12), .Y_PER_MCU(4),
    .RST_INTERVAL(1), .MCU_CNT_W(16)
  ) ub (
    .clk_i(clk), .rst_i(rst_b), .bus(ib.slave)
  );

  assign ia.frame_start_i = ~sel & fs;
  assign ia.blk_valid_i   = ~sel & v;
  assign ia.blk_dc_i      = sel ? 16'd0 : dc;
  assign ia.enc_done_i    = ~sel & done;
  assign ib.frame_start_i = sel & fs;
  assign ib.blk_valid_i   = sel & v;
  assign ib.blk_dc_i      = sel ? dc[11:0] : 12'd0;
  assign ib.enc_done_i    = sel & done;

  assign o_ready  = sel ? ib.blk_ready_o  : ia.blk_ready_o;
  assign o_go     = sel ? ib.enc_go_o     : ia.enc_go_o;
  assign o_chroma = sel ? ib.enc_chroma_o : ia.enc_chroma_o;
  assign o_mcu    = sel ? ib.mcu_done_o   : ia.mcu_done_o;
  assign o_mk     = sel ? ib.rst_marker_o : ia.rst_marker_o;
  assign o_idx    = sel ? ib.rst_idx_o    : ia.rst_idx_o;
  assign o_busy   = sel ? ib.busy_o       : ia.busy_o;
  assign o_diff   = sel ?
    {{4{ib.enc_diff_o[11]}}, ib.enc_diff_o} :
    ia.enc_diff_o;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic pulse_fs;
    tick;
    fs = 1'b1;
    #2;
    total++;
    if (o_ready !== 1'b0 || o_go !== 1'b0) begin
      bad++;
      $display("FAIL fs_block: ready=%b go=%b want 0 0",
               o_ready, o_go);
    end
    tick;
    fs = 1'b0;
  endtask

  task automatic blk(input int d, input int ed,
                     input logic ec, input logic emd,
                     input logic emk, input int eidx,
                     input int dly);
    int n;
    v  = 1'b1;
    dc = 16'(d);
    #2;
    n = 0;
    while (o_ready !== 1'b1 && n < 20) begin
      tick;
      #2;
      n++;
    end
    total++;
    if (o_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_timeout: dc=%0d ready=%b want 1",
               d, o_ready);
    end
    tick;
    v = 1'b0;
    #2;
    total++;
    if (o_go !== 1'b1 || o_diff !== 16'(ed) ||
        o_chroma !== ec || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL issue dc=%0d: go=%b diff=%0d ch=%b busy=%b want 1 %0d %b 1",
               d, o_go, $signed(o_diff), o_chroma, o_busy,
               ed, ec);
    end
    for (int i = 0; i < dly; i++) begin
      tick;
      #2;
      total++;
      if (o_go !== 1'b0 || o_diff !== 16'(ed)) begin
        bad++;
        $display("FAIL wait_hold dc=%0d: go=%b diff=%0d want 0 %0d",
                 d, o_go, $signed(o_diff), ed);
      end
    end
    tick;
    done = 1'b1;
    #2;
    tick;
    done = 1'b0;
    #2;
    total++;
    if (o_mcu !== emd || o_mk !== emk ||
        o_idx !== 3'(eidx) || o_go !== 1'b0 ||
        o_busy !== 1'b1 || o_diff !== 16'(ed) ||
        o_chroma !== ec) begin
      bad++;
      $display("FAIL advance dc=%0d: mcu=%b mk=%b idx=%0d go=%b busy=%b want %b %b %0d 0 1",
               d, o_mcu, o_mk, o_idx, o_go, o_busy,
               emd, emk, eidx);
    end
    tick;
  endtask

  task automatic test_reset;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) tick;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      total++;
      if ({o_ready, o_go, o_chroma, o_mcu, o_mk,
           o_busy} !== 6'b0 || o_idx !== 3'd0 ||
          o_diff !== 16'd0) begin
        bad++;
        $display("FAIL reset inst=%0d: rdy=%b go=%b busy=%b idx=%0d diff=%0d want all 0",
                 s, o_ready, o_go, o_busy, o_idx, o_diff);
      end
    end
    sel = 1'b0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick;
  endtask

  task automatic test_single_mcu;
    sel = 1'b0;
    pulse_fs;
    blk(10, 10, 0, 0, 0, 0, 2);
    blk(12, 2, 0, 0, 0, 0, 2);
    blk(9, -3, 0, 0, 0, 0, 2);
    blk(9, 0, 0, 0, 0, 0, 2);
    blk(5, 5, 1, 0, 0, 0, 2);
    blk(-3, -3, 1, 1, 0, 0, 2);
  endtask

  task automatic test_two_mcu;
    sel = 1'b0;
    pulse_fs;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++)
        blk(100, (m == 0 && i == 0) ? 100 : 0,
            0, 0, 0, 0, 1);
      blk(-50, (m == 0) ? -50 : 0, 1, 0, 0, 0, 1);
      blk(20, (m == 0) ? 20 : 0, 1, 1, 0, 0, 1);
    end
  endtask

  task automatic test_wrap;
    sel = 1'b1;
    pulse_fs;
    blk(2047, 2047, 0, 0, 0, 0, 1);
    blk(-2048, 1, 0, 0, 0, 0, 1);
  endtask

  task automatic test_restart;
    int d;
    sel = 1'b1;
    pulse_fs;
    for (int m = 0; m < 9; m++) begin
      for (int s = 0; s < 4; s++) begin
        d = m * 8 + 1 + s;
        blk(d, (s == 0) ? d : 1, 0, 0, 0, m % 8, 0);
      end
      blk(100 + m, 100 + m, 1, 0, 0, m % 8, 0);
      blk(-(m + 1), -(m + 1), 1, 1, 1, m % 8, 0);
    end
    total++;
    if (o_idx !== 3'd1) begin
      bad++;
      $display("FAIL idx_after_9: got %0d want 1", o_idx);
    end
  endtask

  task automatic test_fs_wait;
    sel = 1'b0;
    pulse_fs;
    v  = 1'b1;
    dc = 16'd50;
    #2;
    tick;
    v = 1'b0;
    #2;
    total++;
    if (o_go !== 1'b1 || o_diff !== 16'd50) begin
      bad++;
      $display("FAIL fsw_issue: go=%b diff=%0d want 1 50",
               o_go, o_diff);
    end
    tick;
    fs   = 1'b1;
    done = 1'b1;
    #2;
    total++;
    if (o_ready !== 1'b0 || o_mcu !== 1'b0 ||
        o_go !== 1'b0) begin
      bad++;
      $display("FAIL fsw_cycle: rdy=%b mcu=%b go=%b want 0 0 0",
               o_ready, o_mcu, o_go);
    end
    tick;
    fs = 1'b0;
    #2;
    total++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL fsw_idle: rdy=%b busy=%b want 1 0",
               o_ready, o_busy);
    end
    tick;
    done = 1'b0;
    blk(7, 7, 0, 0, 0, 0, 1);
  endtask

  task automatic test_fs_issue;
    sel = 1'b0;
    pulse_fs;
    blk(40, 40, 0, 0, 0, 0, 0);
    v  = 1'b1;
    dc = 16'd30;
    #2;
    tick;
    v  = 1'b0;
    fs = 1'b1;
    #2;
    total++;
    if (o_go !== 1'b0 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL fsi_go: go=%b busy=%b want 0 1",
               o_go, o_busy);
    end
    tick;
    fs = 1'b0;
    #2;
    total++;
    if (o_busy !== 1'b0 || o_ready !== 1'b1) begin
      bad++;
      $display("FAIL fsi_idle: busy=%b rdy=%b want 0 1",
               o_busy, o_ready);
    end
    tick;
    blk(4, 4, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back;
    int last_acc, n_acc, run, max_run, n;
    sel = 1'b0;
    pulse_fs;
    v        = 1'b1;
    dc       = 16'd3;
    done     = 1'b1;
    last_acc = -1;
    n_acc    = 0;
    run      = 0;
    max_run  = 0;
    for (int c = 0; c < 30; c++) begin
      #2;
      if (o_go === 1'b1) run++;
      else run = 0;
      if (run > max_run) max_run = run;
      if (o_ready === 1'b1) begin
        if (last_acc >= 0) begin
          total++;
          if (c - last_acc !== 4) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d want 4",
                     c - last_acc);
          end
        end
        last_acc = c;
        n_acc++;
      end
      tick;
    end
    total++;
    if (n_acc < 7 || max_run !== 1) begin
      bad++;
      $display("FAIL b2b_summary: acc=%0d go_run=%0d want >=7 1",
               n_acc, max_run);
    end
    v = 1'b0;
    n = 0;
    #2;
    while (o_busy !== 1'b0 && n < 10) begin
      tick;
      #2;
      n++;
    end
    tick;
    done = 1'b0;
    v    = 1'b1;
    dc   = 16'd9;
    #2;
    tick;
    v = 1'b0;
    tick;
    #2;
    total++;
    if (o_busy !== 1'b1 || o_go !== 1'b0) begin
      bad++;
      $display("FAIL rst_pre_wait: busy=%b go=%b want 1 0",
               o_busy, o_go);
    end
    tick;
    rst_a = 1'b1;
    v     = 1'b1;
    #2;
    total++;
    if (o_ready !== 1'b0 || o_go !== 1'b0) begin
      bad++;
      $display("FAIL rst_same_cycle: rdy=%b go=%b want 0 0",
               o_ready, o_go);
    end
    tick;
    #2;
    total++;
    if ({o_ready, o_go, o_chroma, o_mcu, o_mk,
         o_busy} !== 6'b0 || o_idx !== 3'd0 ||
        o_diff !== 16'd0) begin
      bad++;
      $display("FAIL rst_mid_wait: rdy=%b go=%b busy=%b diff=%0d want all 0",
               o_ready, o_go, o_busy, o_diff);
    end
    tick;
    rst_a = 1'b0;
    v     = 1'b0;
    tick;
    blk(6, 6, 0, 0, 0, 0, 0);
  endtask

  initial begin
    sel  = 1'b0;
    fs   = 1'b0;
    v    = 1'b0;
    done = 1'b0;
    dc   = 16'd0;
    test_reset;
    test_single_mcu;
    test_two_mcu;
    test_wrap;
    test_restart;
    test_fs_wait;
    test_fs_issue;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
